ex_muldiv_ctrl: RTL

Sequencer for the multi-cycle multiply/divide unit attached to the execute stage. It owns the HI/LO registers and runs iterative MULT/MULTU (shift-add) and DIV/DIVU (restoring) on operand magnitudes, with a final sign-fix cycle. While an operation is in flight it stalls IF/ID/EX. It also executes single-cycle MTHI/MTLO, and exposes HI/LO to the EX result mux for MFHI/MFLO.

---
 rtl/ex_muldiv_ctrl.sv | 287 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl -- multi-cycle multiply/divide sequencer for the execute stage.
//
// Owns the architectural HI/LO registers. MULT/MULTU run as a LEN-step
// shift-add on operand magnitudes and DIV/DIVU as a LEN-step restoring
// divide; a final FIX cycle applies the result signs and commits HI/LO.
// MTHI/MTLO write HI/LO in a single cycle without stalling.
// All state updates happen on the falling edge of i_clk, like the pipeline
// latches. i_rst is synchronous and active-low.
//
// Optional build macro:
//   MULDIV_EARLY_EXIT_EN - MUL leaves the iterate phase as soon as the
//                          remaining multiplier bits are all zero.
//
// Ports:
//   i_clk          clock (falling-edge active)
//   i_rst          synchronous active-low reset
//   i_start        EX holds a mul/div/mthi/mtlo instruction
//   i_op           000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO
//   i_dato_a       rs operand (forwarded)
//   i_dato_b       rt operand (forwarded)
//   i_flush        abort an in-flight operation
//   o_stall        freeze PC, IF/ID and ID/EX (combinational)
//   o_busy         sequencer not idle
//   o_done         one-cycle pulse when HI/LO committed
//   o_div_by_zero  pulses with o_done for a divide by zero
//   o_hi, o_lo     architectural HI/LO
module ex_muldiv_ctrl #(
    parameter int LEN      = 32,
    parameter int NB_OP    = 3,
    parameter int NB_COUNT = 6
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [NB_OP-1:0]  i_op,
    input  logic [LEN-1:0]    i_dato_a,
    input  logic [LEN-1:0]    i_dato_b,
    input  logic              i_flush,
    output logic              o_stall,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_div_by_zero,
    output logic [LEN-1:0]    o_hi,
    output logic [LEN-1:0]    o_lo
);

    localparam int LEN2 = 2 * LEN;

    localparam logic [NB_OP-1:0]    OP_MULTU = NB_OP'(3'd0);
    localparam logic [NB_OP-1:0]    OP_MULT  = NB_OP'(3'd1);
    localparam logic [NB_OP-1:0]    OP_DIVU  = NB_OP'(3'd2);
    localparam logic [NB_OP-1:0]    OP_DIV   = NB_OP'(3'd3);
    localparam logic [NB_OP-1:0]    OP_MTHI  = NB_OP'(3'd4);
    localparam logic [NB_OP-1:0]    OP_MTLO  = NB_OP'(3'd5);
    localparam logic [NB_COUNT-1:0] CNT_LAST = NB_COUNT'(LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Two's-complement negate helpers
    function automatic logic [LEN-1:0] neg_word(input logic [LEN-1:0] v);
        return ~v + LEN'(1'b1);
    endfunction

    function automatic logic [LEN2-1:0] neg_wide(input logic [LEN2-1:0] v);
        return ~v + LEN2'(1'b1);
    endfunction

    state_t              state_r;
    state_t              next_s;
    logic                stall_s;
    logic                busy_r;
    logic                done_r;
    logic                dz_r;
    logic [NB_COUNT-1:0] cnt_r;
    logic [LEN2-1:0]     acc_r;      // product accumulator
    logic [LEN2-1:0]     mcand_r;    // multiplicand, shifted left each step
    logic [LEN-1:0]      mplier_r;   // multiplier, shifted right each step
    logic [LEN-1:0]      rem_r;      // partial remainder
    logic [LEN-1:0]      quo_r;      // dividend bits shift out, quotient bits shift in
    logic [LEN-1:0]      dvsr_r;
    logic                neg_p_r;    // negate product / quotient
    logic                neg_r_r;    // negate remainder
    logic                is_div_r;
    logic [LEN-1:0]      hi_r;
    logic [LEN-1:0]      lo_r;

    // Operation decode and operand magnitudes
    logic            is_mul_s;
    logic            is_div_s;
    logic            is_signed_s;
    logic            a_neg_s;
    logic            b_neg_s;
    logic            b_zero_s;
    logic [LEN-1:0]  a_mag_s;
    logic [LEN-1:0]  b_mag_s;

    assign is_mul_s    = (i_op == OP_MULTU) || (i_op == OP_MULT);
    assign is_div_s    = (i_op == OP_DIVU) || (i_op == OP_DIV);
    assign is_signed_s = (i_op == OP_MULT) || (i_op == OP_DIV);
    assign a_neg_s     = is_signed_s & i_dato_a[LEN-1];
    assign b_neg_s     = is_signed_s & i_dato_b[LEN-1];
    assign b_zero_s    = (i_dato_b == {LEN{1'b0}});
    assign a_mag_s     = a_neg_s ? neg_word(i_dato_a) : i_dato_a;
    assign b_mag_s     = b_neg_s ? neg_word(i_dato_b) : i_dato_b;

    // Iteration datapath
    logic [LEN2-1:0] mul_sum_s;
    logic            mul_last_s;
    logic            div_last_s;
    logic [LEN:0]    div_shift_s;
    logic [LEN:0]    div_trial_s;
    logic [LEN2-1:0] prod_fix_s;
    logic [LEN-1:0]  quo_fix_s;
    logic [LEN-1:0]  rem_fix_s;

    assign mul_sum_s   = acc_r + (mplier_r[0] ? mcand_r : {LEN2{1'b0}});
`ifdef MULDIV_EARLY_EXIT_EN
    // Stop once the multiplier bits still to be consumed are all zero.
    assign mul_last_s  = (cnt_r == CNT_LAST) || (mplier_r[LEN-1:1] == {(LEN-1){1'b0}});
`else
    assign mul_last_s  = (cnt_r == CNT_LAST);
`endif
    assign div_last_s  = (cnt_r == CNT_LAST);
    // Partial remainder stays below the divisor, so one extra bit is enough
    // for the trial subtraction; its MSB set means the trial went negative.
    assign div_shift_s = {rem_r, quo_r[LEN-1]};
    assign div_trial_s = div_shift_s - {1'b0, dvsr_r};
    assign prod_fix_s  = neg_p_r ? neg_wide(acc_r) : acc_r;
    assign quo_fix_s   = neg_p_r ? neg_word(quo_r) : quo_r;
    assign rem_fix_s   = neg_r_r ? neg_word(rem_r) : rem_r;

    // Next-state and stall decode
    always_comb begin
        next_s  = state_r;
        stall_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_start && is_mul_s) begin
                    stall_s = 1'b1;
                    next_s  = ST_MUL;
                end else if (i_start && is_div_s) begin
                    stall_s = 1'b1;
                    if (b_zero_s) begin
                        next_s = ST_DONE;
                    end else begin
                        next_s = ST_DIV;
                    end
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                stall_s = 1'b1;
                if (i_flush) begin
                    next_s = ST_IDLE;
                end else if (mul_last_s) begin
                    next_s = ST_FIX;
                end else begin
                    next_s = ST_MUL;
                end
            end
            ST_DIV: begin
                stall_s = 1'b1;
                if (i_flush) begin
                    next_s = ST_IDLE;
                end else if (div_last_s) begin
                    next_s = ST_FIX;
                end else begin
                    next_s = ST_DIV;
                end
            end
            ST_FIX: begin
                stall_s = 1'b1;
                if (i_flush) begin
                    next_s = ST_IDLE;
                end else begin
                    next_s = ST_DONE;
                end
            end
            ST_DONE: begin
                next_s = ST_IDLE;
            end
            default: begin
                next_s = ST_IDLE;
            end
        endcase
    end

    // State register and registered status flags
    always_ff @(negedge i_clk) begin
        if (!i_rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            dz_r    <= 1'b0;
        end else begin
            state_r <= next_s;
            busy_r  <= (next_s != ST_IDLE);
            done_r  <= (next_s == ST_DONE);
            dz_r    <= (state_r == ST_IDLE) && i_start && is_div_s && b_zero_s;
        end
    end

    // Operand latching, iteration steps and HI/LO commit
    always_ff @(negedge i_clk) begin
        if (!i_rst) begin
            cnt_r    <= {NB_COUNT{1'b0}};
            acc_r    <= {LEN2{1'b0}};
            mcand_r  <= {LEN2{1'b0}};
            mplier_r <= {LEN{1'b0}};
            rem_r    <= {LEN{1'b0}};
            quo_r    <= {LEN{1'b0}};
            dvsr_r   <= {LEN{1'b0}};
            neg_p_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            is_div_r <= 1'b0;
            hi_r     <= {LEN{1'b0}};
            lo_r     <= {LEN{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_start) begin
                        cnt_r    <= {NB_COUNT{1'b0}};
                        acc_r    <= {LEN2{1'b0}};
                        mcand_r  <= {{LEN{1'b0}}, a_mag_s};
                        mplier_r <= b_mag_s;
                        rem_r    <= {LEN{1'b0}};
                        quo_r    <= a_mag_s;
                        dvsr_r   <= b_mag_s;
                        neg_p_r  <= a_neg_s ^ b_neg_s;
                        neg_r_r  <= a_neg_s;
                        is_div_r <= is_div_s;
                        if (i_op == OP_MTHI) begin
                            hi_r <= i_dato_a;
                        end
                        if (i_op == OP_MTLO) begin
                            lo_r <= i_dato_a;
                        end
                    end
                end
                ST_MUL: begin
                    acc_r    <= mul_sum_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r + NB_COUNT'(1'b1);
                end
                ST_DIV: begin
                    rem_r <= div_trial_s[LEN] ? div_shift_s[LEN-1:0] : div_trial_s[LEN-1:0];
                    quo_r <= {quo_r[LEN-2:0], ~div_trial_s[LEN]};
                    cnt_r <= cnt_r + NB_COUNT'(1'b1);
                end
                ST_FIX: begin
                    // A flush arriving with FIX wins: nothing is committed.
                    if (!i_flush) begin
                        if (is_div_r) begin
                            hi_r <= rem_fix_s;
                            lo_r <= quo_fix_s;
                        end else begin
                            hi_r <= prod_fix_s[LEN2-1:LEN];
                            lo_r <= prod_fix_s[LEN-1:0];
                        end
                    end
                end
                ST_DONE: begin
                    cnt_r <= {NB_COUNT{1'b0}};
                end
                default: begin
                    cnt_r <= {NB_COUNT{1'b0}};
                end
            endcase
        end
    end

    assign o_stall       = stall_s;
    assign o_busy        = busy_r;
    assign o_done        = done_r;
    assign o_div_by_zero = dz_r;
    assign o_hi          = hi_r;
    assign o_lo          = lo_r;

endmodule
